// File: rtl/nibble_serial_sub_ctrl_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_sub_ctrl_if
// Handshake and data bundle for the nibble-serial subtract sequencer.
//   in_valid / in_ready   : operand handshake (producer -> controller)
//   a_in / b_in           : minuend / subtrahend, WIDTH bits
//   out_valid / out_ready : result handshake (controller -> consumer)
//   diff_out              : A - B result, WIDTH bits
//   borrow_out / zero_out : final borrow, result-is-zero flag
//   busy                  : controller is computing or holding a result
// Modports: master = producer/consumer side, slave = controller side.
// ---------------------------------------------------------------------------
interface nibble_serial_sub_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
  logic             zero_out;
  logic             busy;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, diff_out, borrow_out, zero_out, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, diff_out, borrow_out, zero_out, busy
  );
endinterface

// File: rtl/nibble_serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_sub_ctrl
// Multi-precision subtract sequencer: computes A - B on WIDTH-bit operands by
// running one 4-bit subtract slice per nibble, LSB nibble first, with the
// borrow carried between passes in a register.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : nibble_serial_sub_ctrl_if.slave (operand/result handshakes,
//           diff_out, borrow_out, zero_out, busy)
//
// Parameters:
//   WIDTH : operand/result width; multiple of 4, at least 4.
//
// Build option:
//   NIBBLE_SUB_SAT_EN : when defined, a result with final borrow = 1 is
//                       saturated to zero (zero_out = 1, borrow_out = 1).
//
// Latency: operands accepted at edge N give out_valid = 1 after edge
// N + WIDTH/4. Result holds until the consumer handshake.
// ---------------------------------------------------------------------------
module nibble_serial_sub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nibble_serial_sub_ctrl_if.slave  bus
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  // Reject illegal widths at elaboration.
  generate
    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
      $error("nibble_serial_sub_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One 4-bit slice: {borrow_out, diff[3:0]} = a - b - borrow_in.
  function automatic logic [4:0] sub_slice(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic       bin);
    return {1'b0, a} - {1'b0, b} - {4'b0000, bin};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic             borrow_r;
  logic [CNT_W-1:0] cnt_r;

  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_out_r;
  logic             zero_out_r;

  logic [4:0]       slice_s;
  logic [WIDTH-1:0] res_next_s;
  logic [WIDTH-1:0] final_diff_s;
  logic             last_s;

  // Slice arithmetic on the low nibbles and the exit condition.
  always_comb begin
    slice_s = sub_slice(a_sh_r[3:0], b_sh_r[3:0], borrow_r);
    last_s  = (cnt_r == LAST_CNT);
  end

  // Result register fills from the MSB side, so after NIBBLES passes the
  // first (least significant) slice has reached bits [3:0].
  generate
    if (WIDTH == 4) begin : g_res_w4
      assign res_next_s = slice_s[3:0];
    end else begin : g_res_wide
      assign res_next_s = {slice_s[3:0], res_r[WIDTH-1:4]};
    end
  endgenerate

  // Final result value presented on the last pass.
  always_comb begin
    final_diff_s = res_next_s;
`ifdef NIBBLE_SUB_SAT_EN
    if (slice_s[4]) begin
      final_diff_s = {WIDTH{1'b0}};
    end else begin
      final_diff_s = res_next_s;
    end
`endif
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      a_sh_r       <= {WIDTH{1'b0}};
      b_sh_r       <= {WIDTH{1'b0}};
      res_r        <= {WIDTH{1'b0}};
      borrow_r     <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      diff_r       <= {WIDTH{1'b0}};
      borrow_out_r <= 1'b0;
      zero_out_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_sh_r     <= bus.a_in;
            b_sh_r     <= bus.b_in;
            res_r      <= {WIDTH{1'b0}};
            borrow_r   <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh_r   <= a_sh_r >> 3'd4;
          b_sh_r   <= b_sh_r >> 3'd4;
          res_r    <= res_next_s;
          borrow_r <= slice_s[4];
          if (last_s) begin
            cnt_r        <= {CNT_W{1'b0}};
            diff_r       <= final_diff_s;
            borrow_out_r <= slice_s[4];
            zero_out_r   <= (final_diff_s == {WIDTH{1'b0}});
            out_valid_r  <= 1'b1;
            state_r      <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Result fields hold across the handshake; only flags change.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.busy       = busy_r;
  assign bus.diff_out   = diff_r;
  assign bus.borrow_out = borrow_out_r;
  assign bus.zero_out   = zero_out_r;

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_sub_ctrl
// Directed self-checking bench for nibble_serial_sub_ctrl (WIDTH=16 and a
// second instance at WIDTH=4). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_nibble_serial_sub_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nibble_serial_sub_ctrl_if #(.WIDTH(16)) bus16 ();
  nibble_serial_sub_ctrl_if #(.WIDTH(4))  bus4 ();

  nibble_serial_sub_ctrl #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  nibble_serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand pair, wait for acceptance, then count edges until
  // out_valid (bounded). lat is the number of edges after the accept edge.
  task automatic run_op16(input logic [15:0] a, input logic [15:0] b,
                          output int lat);
    bus16.a_in     = a;
    bus16.b_in     = b;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    lat = 0;
    while ((bus16.out_valid !== 1'b1) && (lat < 20)) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus16.in_ready, bus16.out_valid, bus16.busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b expected 100",
               {bus16.in_ready, bus16.out_valid, bus16.busy});
    end
    checks++;
    if ({bus16.diff_out, bus16.borrow_out, bus16.zero_out} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got diff=%h borrow=%b zero=%b expected 0",
               bus16.diff_out, bus16.borrow_out, bus16.zero_out);
    end
  endtask

  task automatic test_basic();
    int lat;
    bus16.out_ready = 1'b1;
    run_op16(16'h9376, 16'h1234, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 4", lat);
    end
    checks++;
    if ({bus16.diff_out, bus16.borrow_out, bus16.zero_out} !== {16'h8142, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: got diff=%h b=%b z=%b expected 8142 0 0",
               bus16.diff_out, bus16.borrow_out, bus16.zero_out);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus16.out_valid, bus16.in_ready, bus16.busy} !== 3'b010) begin
      errors++;
      $display("FAIL basic_handshake: got vld/rdy/busy=%b expected 010",
               {bus16.out_valid, bus16.in_ready, bus16.busy});
    end
  endtask

  task automatic test_borrow_chain();
    int lat;
    run_op16(16'h1000, 16'h0001, lat);
    checks++;
    if ({bus16.diff_out, bus16.borrow_out, bus16.zero_out} !== {16'h0FFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL borrow_chain: got diff=%h b=%b z=%b expected 0fff 0 0",
               bus16.diff_out, bus16.borrow_out, bus16.zero_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_underflow();
    int lat;
    logic [17:0] exp_v;
`ifdef NIBBLE_SUB_SAT_EN
    exp_v = {16'h0000, 1'b1, 1'b1};
`else
    exp_v = {16'hFFFB, 1'b1, 1'b0};
`endif
    run_op16(16'h0004, 16'h0009, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL underflow_latency: got %0d expected 4", lat);
    end
    checks++;
    if ({bus16.diff_out, bus16.borrow_out, bus16.zero_out} !== exp_v) begin
      errors++;
      $display("FAIL underflow: got diff=%h b=%b z=%b expected %h %b %b",
               bus16.diff_out, bus16.borrow_out, bus16.zero_out,
               exp_v[17:2], exp_v[1], exp_v[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op16(16'hFFFF, 16'hFFFF, lat);
    checks++;
    if ({bus16.diff_out, bus16.borrow_out, bus16.zero_out} !== {16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL equal_ops: got diff=%h b=%b z=%b expected 0000 0 1",
               bus16.diff_out, bus16.borrow_out, bus16.zero_out);
    end
    @(posedge clk); #1;
    // Handshake edge just passed; the next edge accepts the second op.
    run_op16(16'h000A, 16'h0002, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL b2b_latency: got %0d expected 4", lat);
    end
    checks++;
    if ({bus16.diff_out, bus16.borrow_out, bus16.zero_out} !== {16'h0008, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_result: got diff=%h b=%b z=%b expected 0008 0 0",
               bus16.diff_out, bus16.borrow_out, bus16.zero_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    bus16.out_ready = 1'b0;
    run_op16(16'h5555, 16'h1111, lat);
    checks++;
    if (bus16.diff_out !== 16'h4444) begin
      errors++;
      $display("FAIL bp_result: got diff=%h expected 4444", bus16.diff_out);
    end
    for (int i = 0; i < 7; i++) begin
      bus16.in_valid = 1'b1;
      bus16.a_in     = 16'h0F00 + 16'(i);
      bus16.b_in     = 16'h0001 + 16'(i);
      @(posedge clk); #1;
      checks++;
      if ({bus16.out_valid, bus16.in_ready, bus16.busy, bus16.diff_out,
           bus16.borrow_out, bus16.zero_out} !== {3'b101, 16'h4444, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld/rdy/busy=%b diff=%h b=%b z=%b expected 101 4444 0 0",
                 i, {bus16.out_valid, bus16.in_ready, bus16.busy},
                 bus16.diff_out, bus16.borrow_out, bus16.zero_out);
      end
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus16.out_valid, bus16.in_ready, bus16.diff_out} !== {2'b01, 16'h4444}) begin
      errors++;
      $display("FAIL bp_release: got vld/rdy=%b diff=%h expected 01 4444",
               {bus16.out_valid, bus16.in_ready}, bus16.diff_out);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bus16.a_in     = 16'h1234;
    bus16.b_in     = 16'h0034;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus16.out_valid, bus16.in_ready, bus16.busy, bus16.diff_out} !== {3'b010, 16'h0000}) begin
      errors++;
      $display("FAIL mid_run_reset: got vld/rdy/busy=%b diff=%h expected 010 0000",
               {bus16.out_valid, bus16.in_ready, bus16.busy}, bus16.diff_out);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_no_result: got out_valid=%b expected 0", bus16.out_valid);
    end
    run_op16(16'h0007, 16'h0005, lat);
    checks++;
    if ({bus16.diff_out, bus16.borrow_out, bus16.zero_out} !== {16'h0002, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_op: got diff=%h b=%b z=%b expected 0002 0 0",
               bus16.diff_out, bus16.borrow_out, bus16.zero_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width4();
    int lat;
    bus4.out_ready = 1'b1;
    bus4.a_in      = 4'h9;
    bus4.b_in      = 4'h3;
    bus4.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    lat = 0;
    while ((bus4.out_valid !== 1'b1) && (lat < 20)) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL w4_latency: got %0d expected 1", lat);
    end
    checks++;
    if ({bus4.diff_out, bus4.borrow_out, bus4.zero_out} !== {4'h6, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL w4_result: got diff=%h b=%b z=%b expected 6 0 0",
               bus4.diff_out, bus4.borrow_out, bus4.zero_out);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus4.out_valid, bus4.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL w4_handshake: got vld/rdy=%b expected 01",
               {bus4.out_valid, bus4.in_ready});
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.a_in      = 16'h0000;
    bus16.b_in      = 16'h0000;
    bus16.out_ready = 1'b0;
    bus4.in_valid   = 1'b0;
    bus4.a_in       = 4'h0;
    bus4.b_in       = 4'h0;
    bus4.out_ready  = 1'b0;
    #12;
    test_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_borrow_chain();
    test_underflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_sub_ctrl.md
Name: nibble_serial_sub_ctrl

Overview:
- Multi-precision subtract sequencer. Computes A - B on WIDTH-bit operands by running one 4-bit subtract slice once per nibble, LSB nibble first.
- Borrow is carried between nibbles in a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Lets the team's 4-bit subtractor serve wide operands without replicating the datapath.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of 4 and at least 4. Other values are illegal; an elaboration-time check is required.
- NIBBLES, WIDTH/4, derived localparam (not overridable). Number of slice passes per operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  controller can accept operands.
- a_in  in  WIDTH  minuend.
- b_in  in  WIDTH  subtrahend.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff_out  out  WIDTH  A - B modulo 2^WIDTH (see optional feature).
- borrow_out  out  1  1 when A < B (unsigned).
- zero_out  out  1  1 when diff_out == 0.
- busy  out  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (async assert, sync release):
  - state = IDLE.
  - in_ready = 1, out_valid = 0, busy = 0.
  - diff_out = 0, borrow_out = 0, zero_out = 0.
  - Internal shift registers, borrow register and nibble counter cleared.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a rising edge: latch a_in and b_in into shift registers, clear the borrow register, set the counter to 0, go to RUN.
  - Operand inputs are ignored at all other times.
- RUN (in_ready = 0, busy = 1), once per cycle:
  - Compute slice = {1'b0, A_sh[3:0]} - {1'b0, B_sh[3:0]} - borrow_reg, as a 5-bit result.
  - Shift slice[3:0] into the result register from the MSB side.
  - Shift A_sh and B_sh right by 4.
  - borrow_reg <= slice[4].
  - counter increments.
- RUN exit: on the cycle the counter equals NIBBLES-1, the state goes to DONE on the next edge. In that same edge update:
  - diff_out gets the full assembled result.
  - borrow_out gets the final borrow.
  - zero_out gets (result == 0).
  - out_valid becomes 1.
- Latency: operands accepted at edge N give out_valid = 1 after edge N+NIBBLES. For WIDTH=16 that is 4 cycles after acceptance.
- DONE:
  - out_valid = 1.
  - diff_out, borrow_out and zero_out are held stable while out_ready = 0. Arbitrary stall length is allowed.
  - On out_valid & out_ready at an edge: go to IDLE and clear out_valid. diff_out, borrow_out and zero_out hold their last value.
- No input/output overlap: a new operand pair can be accepted at the earliest one cycle after the result handshake. Throughput is one op per NIBBLES+2 cycles.
- Simultaneous events:
  - in_valid while busy is ignored; the producer must hold it.
  - out_ready outside DONE has no effect.
- Counter width is $clog2(NIBBLES), minimum 1 bit. It never exceeds NIBBLES-1.
- WIDTH=4 boundary: RUN lasts exactly one cycle.
- Reset mid-RUN or mid-DONE: the operation is aborted, all outputs return to reset values immediately, and no result is produced.
- Arithmetic: borrow_out = 1 exactly when a_in < b_in, unsigned. zero_out always reflects the final diff_out value.

Optional Feature:
- Macro: NIBBLE_SUB_SAT_EN.
- Defined (saturating subtract): when the final borrow is 1, diff_out is forced to 0 and zero_out is 1. borrow_out still reports 1. Latency is unchanged.
- Undefined: diff_out is the modulo-2^WIDTH wrap result, as described above. No saturation logic is present.

Test Plan (WIDTH=16, unless noted):
- Basic subtract: a=0x9376, b=0x1234, out_ready held 1 → out_valid 4 cycles after accept; diff=0x8142, borrow=0, zero=0.
- Borrow chain across all nibbles: a=0x1000, b=0x0001 → diff=0x0FFF, borrow=0.
- Underflow: a=0x0004, b=0x0009 → diff=0xFFFB, borrow=1, zero=0. With NIBBLE_SUB_SAT_EN: diff=0x0000, borrow=1, zero=1.
- Equal operands and back-to-back ops:
  - a=b=0xFFFF → diff=0, borrow=0, zero=1.
  - Then a second op 0x000A-0x0002 is accepted the cycle after the handshake → diff=0x0008.
- Backpressure: out_ready=0 for 7 cycles in DONE → out_valid and outputs stable; in_ready=0; a changing a_in/b_in with in_valid=1 is ignored. Release → handshake, in_ready=1 next cycle.
- Reset mid-RUN: assert rst_n=0 two cycles after accept → out_valid=0, diff_out=0, in_ready=1 immediately. After release, 0x0007-0x0005 → diff=0x0002. Also rerun the basic case with WIDTH=4: 9-3 gives diff=6 after 1 cycle.
